// File: rtl/roce_qp_tx_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// RoCE_params
// Shared RoCE transmit constants:
//   MAX_QUEUE_PAIRS   default number of scheduled queue pairs
//   RNR_TIMER_VALUES  InfiniBand RNR timer table (AETH RNR timer field ->
//                     backoff length in network clock cycles, 4 ns clock)
//   sched_state_t     TX scheduler FSM states
// ---------------------------------------------------------------------------
package RoCE_params;

   localparam int MAX_QUEUE_PAIRS = 4;

   // IB RNR timer table in microseconds multiplied by 250 cycles/us.
   // Code 0 is the longest entry (655.36 ms), not zero.
   localparam logic [31:0] RNR_TIMER_VALUES [32] = '{
      32'd163840000, 32'd2500,      32'd5000,      32'd7500,
      32'd10000,     32'd15000,     32'd20000,     32'd30000,
      32'd40000,     32'd60000,     32'd80000,     32'd120000,
      32'd160000,    32'd240000,    32'd320000,    32'd480000,
      32'd640000,    32'd960000,    32'd1280000,   32'd1920000,
      32'd2560000,   32'd3840000,   32'd5120000,   32'd7680000,
      32'd10240000,  32'd15360000,  32'd20480000,  32'd30720000,
      32'd40960000,  32'd61440000,  32'd81920000,  32'd122880000
   };

   typedef enum logic [0:0] {
      SCHED_IDLE  = 1'b0,
      SCHED_GRANT = 1'b1
   } sched_state_t;

endpackage

// File: rtl/roce_qp_tx_scheduler_rnr_backoff_timer.sv
// ---------------------------------------------------------------------------
// roce_rnr_backoff_timer
// Per-QP RNR backoff down-counter. Saturates at zero.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   load             load load_value (wins over decrement)
//   load_value[31:0] backoff length in cycles
//   clear            force counter to zero (QP left RTS)
//   busy             counter is non-zero
// ---------------------------------------------------------------------------
module roce_rnr_backoff_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_value,
   input  logic        clear,
   output logic        busy
);

   logic [31:0] count_q, count_d;

   // NOTE: count_d gets its default first so every path assigns it and no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_value;
      end else if (count_q != '0) begin
         count_d = count_q - 32'd1;
      end
   end

   // NOTE: registered state is updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign busy = (count_q != '0);

endmodule

// File: rtl/roce_qp_tx_scheduler.sv
// ---------------------------------------------------------------------------
// roce_qp_tx_scheduler
// Round-robin scheduler granting one eligible queue pair at a time to the
// RoCE TX header generator. Eligible = pending & in RTS & not in RNR backoff.
// Build option: ROCE_QP_SCHED_RNR_BACKOFF_EN enables the per-QP RNR backoff
// counters; without it rnr_* are ignored and qp_backoff is 0.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_req_valid     per-QP work request pending (level)
//   s_req_ack       one-hot, high in the cycle the grant for that QP handshakes
//   qp_enable       per-QP in RTS
//   m_grant_valid   grant presented downstream
//   m_grant_ready   downstream accepts grant
//   m_grant_qp_idx  granted QP index
//   rnr_valid       RNR NAK event pulse
//   rnr_qp_idx      QP the RNR NAK applies to
//   rnr_timer_code  AETH RNR timer field
//   qp_backoff      per-QP backoff active
// ---------------------------------------------------------------------------
module roce_qp_tx_scheduler
   import RoCE_params::*;
#(
   parameter int NUM_QP   = MAX_QUEUE_PAIRS,
   parameter int QP_IDX_W = $clog2(NUM_QP)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_QP-1:0]   s_req_valid,
   output logic [NUM_QP-1:0]   s_req_ack,
   input  logic [NUM_QP-1:0]   qp_enable,
   output logic                m_grant_valid,
   input  logic                m_grant_ready,
   output logic [QP_IDX_W-1:0] m_grant_qp_idx,
   input  logic                rnr_valid,
   input  logic [QP_IDX_W-1:0] rnr_qp_idx,
   input  logic [4:0]          rnr_timer_code,
   output logic [NUM_QP-1:0]   qp_backoff
);

   sched_state_t        state_q, state_d;
   logic [QP_IDX_W-1:0] ptr_q, ptr_d;
   logic [QP_IDX_W-1:0] grant_idx_q, grant_idx_d;
   logic [NUM_QP-1:0]   eligible;
   logic                sel_found;
   logic [QP_IDX_W-1:0] sel_idx;

   // ---------------- RNR backoff ----------------
`ifdef ROCE_QP_SCHED_RNR_BACKOFF_EN
   logic [31:0] rnr_load_value;
   assign rnr_load_value = RNR_TIMER_VALUES[rnr_timer_code];

   for (genvar i = 0; i < NUM_QP; i++) begin : g_backoff
      // RNR NAKs for a QP outside RTS are dropped; leaving RTS clears backoff.
      roce_rnr_backoff_timer u_timer (
         .clk        (clk),
         .rst        (rst),
         .load       (rnr_valid && (rnr_qp_idx == QP_IDX_W'(i)) && qp_enable[i]),
         .load_value (rnr_load_value),
         .clear      (!qp_enable[i]),
         .busy       (qp_backoff[i])
      );
   end
`else
   logic unused_rnr;
   assign unused_rnr = ^{rnr_valid, rnr_qp_idx, rnr_timer_code};
   assign qp_backoff = '0;
`endif

   assign eligible = s_req_valid & qp_enable & ~qp_backoff;

   // ---------------- round-robin pick ----------------
   // Search starts just after the last granted QP and wraps, so the last
   // winner has lowest priority.
   always_comb begin : rr_select
      logic [QP_IDX_W-1:0] cand;
      sel_found = 1'b0;
      sel_idx   = ptr_q;
      cand      = '0;
      for (int off = 1; off <= NUM_QP; off++) begin
         cand = QP_IDX_W'((int'(ptr_q) + off) % NUM_QP);
         if (!sel_found && eligible[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   // ---------------- FSM ----------------
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_idx_d = grant_idx_q;
      s_req_ack   = '0;
      case (state_q)
         SCHED_IDLE: begin
            if (sel_found) begin
               grant_idx_d = sel_idx;
               state_d     = SCHED_GRANT;
            end
         end
         SCHED_GRANT: begin
            // Grant is never retracted; only the handshake releases it.
            if (m_grant_ready) begin
               // A grant cut short by reset is not acknowledged upstream.
               s_req_ack[grant_idx_q] = !rst;
               ptr_d                  = grant_idx_q;
               state_d                = SCHED_IDLE;
            end
         end
         default: state_d = SCHED_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SCHED_IDLE;
         ptr_q       <= QP_IDX_W'(NUM_QP - 1);   // QP0 wins first after reset
         grant_idx_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_idx_q <= grant_idx_d;
      end
   end

   assign m_grant_valid  = (state_q == SCHED_GRANT);
   assign m_grant_qp_idx = grant_idx_q;

endmodule
